cache_refill_ctrl: RTL and testbench

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

---
 rtl/cache_refill_ctrl_pkg.sv | 33 +++
 rtl/cache_refill_ctrl_sat.sv | 35 +++
 rtl/cache_refill_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_refill_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl_pkg
// Purpose : Shared types and constants for the cache refill controller.
//           Holds the refill FSM state enum, the line geometry (words per
//           line, word/line widths) and the memory/line address widths.
//           Also provides a helper that extracts word k from a packed line.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package cache_refill_ctrl_pkg;

  localparam int LINE_WORDS = 4;                      // words per cache line
  localparam int WORD_W     = 32;                     // bits per word
  localparam int LINE_W     = LINE_WORDS * WORD_W;    // bits per line
  localparam int WIDX_W     = 2;                      // word index width
  localparam int LADDR_W    = 6;                      // line address {tag,set}
  localparam int MADDR_W    = LADDR_W + WIDX_W;       // memory word address

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2,
    ST_UPD  = 2'd3
  } state_t;

  // Word 0 sits in the most significant slot of a line.
  function automatic logic [WORD_W-1:0] line_word(
    input logic [LINE_W-1:0] line,
    input logic [WIDX_W-1:0] k
  );
    return line[LINE_W-1 - WORD_W*int'(k) -: WORD_W];
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_sat.sv
// -----------------------------------------------------------------------------
// sat_counter
// Purpose : Event counter that sticks at all-ones instead of wrapping.
// Ports   : clk    - clock
//           reset  - asynchronous active-low reset, clears the count
//           inc    - count one event this cycle
//           count  - current count (CNT_W bits)
// -----------------------------------------------------------------------------
module sat_counter
  import cache_refill_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;
  logic             w_full;

  assign w_full = (r_count == {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (inc && !w_full) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl
// Purpose : On a CPU miss, optionally writes the dirty victim line back to
//           memory one word at a time, then reads the requested line one word
//           at a time and presents it to the cache with a one-cycle update
//           pulse. Counts completed writebacks and refills (saturating).
// Ports   : clk        - clock, all state changes on its rising edge
//           reset      - asynchronous active-low reset
//           req        - CPU access valid
//           add[31:0]  - CPU byte address (bits 7:2 select the line)
//           miss_i     - cache miss flag
//           dirty_i    - victim line dirty flag
//           writeback  - victim line (word0 in [127:96])
//           wadd[5:0]  - victim line address
//           update     - one-cycle pulse, load d into the cache
//           d          - assembled refill line (word0 in [127:96])
//           stall      - CPU must hold its access
//           mem_req / mem_we / mem_addr / mem_wdata - memory word request
//           mem_rdata / mem_ack                     - memory word response
//           wb_cnt / fill_cnt - completed writeback / refill counts
// -----------------------------------------------------------------------------
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [31:0]       add,
  input  logic              miss_i,
  input  logic              dirty_i,
  input  logic [127:0]      writeback,
  input  logic [5:0]        wadd,
  output logic              update,
  output logic [127:0]      d,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [7:0]        mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  wb_cnt,
  output logic [CNT_W-1:0]  fill_cnt
);

  localparam logic [WIDX_W-1:0] LAST_K = WIDX_W'(LINE_WORDS - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [WIDX_W-1:0]   r_k;
  logic [LINE_W-1:0]   r_wb_line;
  logic [LINE_W-1:0]   r_d;
  logic [LADDR_W-1:0]  r_wadd;
  logic [LADDR_W-1:0]  r_fadd;

  logic                w_start;
  logic                w_xfer;
  logic                w_last;
  logic                w_mem_req;
  logic                w_mem_we;
  logic [MADDR_W-1:0]  w_mem_addr;
  logic [WORD_W-1:0]   w_mem_wdata;
  logic                w_update;
  logic                w_wb_done;
  logic                w_unused;

  // Only the line-select bits of the CPU address matter here.
  assign w_unused = ^{add[31:8], add[1:0]};

  assign w_start = req & miss_i;
  // Ack is only meaningful while a request is outstanding; this also makes
  // any ack seen in IDLE or UPD harmless.
  assign w_xfer  = w_mem_req & mem_ack;
  assign w_last  = (r_k == LAST_K);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and memory-side outputs. Address and write data come only from
  // latched registers and r_k, so they hold still until the word is acked.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = '0;
    w_mem_wdata  = '0;
    w_update     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_next = dirty_i ? ST_WB : ST_FILL;
        end
      end
      ST_WB: begin
        w_mem_req   = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = {r_wadd, r_k};
        w_mem_wdata = line_word(r_wb_line, r_k);
        if (mem_ack && w_last) begin
          w_state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        w_mem_req  = 1'b1;
        w_mem_addr = {r_fadd, r_k};
        if (mem_ack && w_last) begin
          w_state_next = ST_UPD;
        end
      end
      ST_UPD: begin
        w_update     = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: miss latches, word index and refill line assembly.
  // r_k steps on the ack edge itself so consecutive words go out back to back.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k       <= '0;
      r_wb_line <= '0;
      r_wadd    <= '0;
      r_fadd    <= '0;
      r_d       <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_start) begin
        r_wb_line <= writeback;
        r_wadd    <= wadd;
        r_fadd    <= add[7:2];
        r_k       <= '0;
      end
    end else if (w_xfer) begin
      // Wrap to zero after the last word so FILL starts again at word 0.
      r_k <= w_last ? '0 : r_k + WIDX_W'(1);
      if (r_state == ST_FILL) begin
        r_d[LINE_W-1 - WORD_W*int'(r_k) -: WORD_W] <= mem_rdata;
      end
    end
  end

  assign w_wb_done = (r_state == ST_WB) & w_xfer & w_last;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  sat_counter #(.CNT_W(CNT_W)) u_wb_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_wb_done),
    .count (wb_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fill_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_update),
    .count (fill_cnt)
  );

  assign update    = w_update;
  assign d         = r_d;
  assign stall     = (r_state != ST_IDLE) | w_start;
  assign mem_req   = w_mem_req;
  assign mem_we    = w_mem_we;
  assign mem_addr  = w_mem_addr;
  assign mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_cache_refill_ctrl
// Self-checking bench: memory transfers and refill lines are predicted when a
// miss is driven and compared as the DUT produces them. A second instance
// with 2-bit counters exercises counter saturation in a few misses.
// -----------------------------------------------------------------------------
module tb_cache_refill_ctrl;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          req;
  logic [31:0]   add;
  logic          miss_i;
  logic          dirty_i;
  logic [127:0]  writeback;
  logic [5:0]    wadd;
  logic          update;
  logic [127:0]  d;
  logic          stall;
  logic          mem_req;
  logic          mem_we;
  logic [7:0]    mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ack;
  logic [15:0]   wb_cnt;
  logic [15:0]   fill_cnt;

  logic [1:0]    s_wb_cnt;
  logic [1:0]    s_fill_cnt;
  logic          s_unused_update, s_unused_stall, s_unused_req, s_unused_we;
  logic [127:0]  s_unused_d;
  logic [7:0]    s_unused_addr;
  logic [31:0]   s_unused_wdata;

  cache_refill_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .add(add), .miss_i(miss_i),
    .dirty_i(dirty_i), .writeback(writeback), .wadd(wadd), .update(update),
    .d(d), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .wb_cnt(wb_cnt), .fill_cnt(fill_cnt)
  );

  cache_refill_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .req(req), .add(add), .miss_i(miss_i),
    .dirty_i(dirty_i), .writeback(writeback), .wadd(wadd),
    .update(s_unused_update), .d(s_unused_d), .stall(s_unused_stall),
    .mem_req(s_unused_req), .mem_we(s_unused_we), .mem_addr(s_unused_addr),
    .mem_wdata(s_unused_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_cnt(s_wb_cnt), .fill_cnt(s_fill_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_upd = 0;
  int exp_fills = 0;
  int exp_wbs = 0;

  // ---------------------------------------------------------------- memory
  logic        ack_force = 1'b0;
  logic        resp_ack  = 1'b0;
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic [31:0] rd_base   = '0;

  assign mem_ack   = ack_force | resp_ack;
  assign mem_rdata = rd_base + {30'h0, mem_addr[1:0]};

  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (wait_cnt >= ack_delay) begin
        resp_ack = 1'b1;
        wait_cnt = 0;
      end else begin
        resp_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      resp_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // ------------------------------------------------------------ scoreboard
  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t        xq[$];
  logic [127:0] lq[$];
  xfer_t        m_exp;
  logic [127:0] m_line;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  logic        prev_wait = 1'b0;
  logic [7:0]  prev_addr;
  logic [31:0] prev_wdata;
  logic        prev_we;

  always @(negedge clk) begin
    if (prev_wait && mem_req) begin
      chk("hold_addr", mem_addr, prev_addr);
      chk("hold_wdata", mem_wdata, prev_wdata);
      chk("hold_we", mem_we, prev_we);
    end
    prev_wait  = mem_req & ~mem_ack;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
    prev_we    = mem_we;
    if (mem_req && mem_ack) begin
      if (xq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL xfer_unexpected: got addr %h we %b, required no transfer", mem_addr, mem_we);
      end else begin
        m_exp = xq.pop_front();
        chk("xfer_we", mem_we, m_exp.we);
        chk("xfer_addr", mem_addr, m_exp.addr);
        if (m_exp.we) chk("xfer_wdata", mem_wdata, m_exp.wdata);
        $display("xfer we=%b addr=%h wdata=%h", mem_we, mem_addr, mem_wdata);
      end
    end
    if (update) begin
      n_upd++;
      if (lq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL update_unexpected: got d %h, required no update", d);
      end else begin
        m_line = lq.pop_front();
        chk("update_d", d, m_line);
        $display("update d=%h", d);
      end
    end
  end

  // ------------------------------------------------------------- helpers
  task automatic push_expect(input logic dirty, input logic [5:0] wa,
                             input logic [127:0] wl, input logic [5:0] la,
                             input logic [31:0] base);
    xfer_t t;
    if (dirty) begin
      for (int k = 0; k < 4; k++) begin
        t.we = 1'b1; t.addr = {wa, k[1:0]}; t.wdata = wl[127-32*k -: 32];
        xq.push_back(t);
      end
      exp_wbs++;
    end
    for (int k = 0; k < 4; k++) begin
      t.we = 1'b0; t.addr = {la, k[1:0]}; t.wdata = '0;
      xq.push_back(t);
    end
    lq.push_back({base, base + 32'd1, base + 32'd2, base + 32'd3});
    exp_fills++;
  endtask

  task automatic scramble_idle_inputs();
    req       = 1'b0;
    miss_i    = 1'($urandom_range(0, 1));
    dirty_i   = 1'($urandom_range(0, 1));
    add       = $urandom;
    wadd      = 6'($urandom);
    writeback = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Drives one miss cycle, then drops req and scrambles miss/dirty.
  task automatic start_miss(input logic dirty, input logic [31:0] a,
                            input logic [5:0] wa, input logic [127:0] wl,
                            input logic [31:0] base);
    @(posedge clk); #2;
    req = 1'b1; miss_i = 1'b1; dirty_i = dirty; add = a; wadd = wa;
    writeback = wl; rd_base = base;
    push_expect(dirty, wa, wl, a[7:2], base);
    @(posedge clk); #2;
    scramble_idle_inputs();
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      cycles++;
      if (cycles > 200) begin
        n_vec++; n_err++;
        $display("FAIL idle_timeout: got stall still high after %0d cycles, required return to idle", cycles);
        break;
      end
    end
  endtask

  task automatic chk_counts();
    chk("wb_cnt", wb_cnt, 16'(exp_wbs));
    chk("fill_cnt", fill_cnt, 16'(exp_fills));
    chk("sat_wb_cnt", s_wb_cnt, (exp_wbs > 3) ? 2'd3 : 2'(exp_wbs));
    chk("sat_fill_cnt", s_fill_cnt, (exp_fills > 3) ? 2'd3 : 2'(exp_fills));
  endtask

  // ------------------------------------------------------------- vectors
  typedef struct {
    logic req;
    logic miss;
    logic dirty;
    logic ack_f;
    logic exp_stall;
    int   exp_lat;
  } vec_t;

  vec_t         vt[10];
  int           lat;
  int           upd_before;
  logic [31:0]  t_add;
  logic [5:0]   t_wadd;
  logic [127:0] t_wl;
  logic [31:0]  t_base;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vt[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};   // ack while idle
    vt[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    vt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5};
    vt[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 9};
    vt[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vt[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5};
    vt[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 9};

    // Reset state, checked before any clock edge.
    reset = 1'b0; req = 1'b0; add = '0; miss_i = 1'b0; dirty_i = 1'b0;
    writeback = '0; wadd = '0;
    #1;
    chk("rst_update", update, 1'b0);
    chk("rst_d", d, 128'h0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk_counts();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // Clean miss at 0x34 with zero-wait memory.
    start_miss(1'b0, 32'h0000_0034, 6'h15, 128'h1, 32'h0000_00A0);
    wait_idle(lat);
    chk("clean_latency", lat, 5);
    chk_counts();
    $display("clean miss: latency %0d, fill_cnt %0d", lat, fill_cnt);

    // Dirty miss: victim 0x2D, fill from 0x10.
    start_miss(1'b1, 32'h0000_0010, 6'h2D,
               128'h11110000_22220001_33330002_44440003, 32'h5500_0000);
    wait_idle(lat);
    chk("dirty_latency", lat, 9);
    chk_counts();
    $display("dirty miss: latency %0d, wb_cnt %0d", lat, wb_cnt);

    // Table of idle-state input combinations.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      t_add  = $urandom;
      t_wadd = 6'($urandom);
      t_wl   = {$urandom, $urandom, $urandom, $urandom};
      t_base = $urandom;
      req = vt[i].req; miss_i = vt[i].miss; dirty_i = vt[i].dirty;
      ack_force = vt[i].ack_f; add = t_add; wadd = t_wadd;
      writeback = t_wl; rd_base = t_base;
      if (vt[i].req && vt[i].miss) push_expect(vt[i].dirty, t_wadd, t_wl, t_add[7:2], t_base);
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), stall, vt[i].exp_stall);
      chk($sformatf("vec%0d_idle_mem_req", i), mem_req, 1'b0);
      @(posedge clk); #2;
      ack_force = 1'b0;
      scramble_idle_inputs();
      wait_idle(lat);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
      chk_counts();
      $display("vec%0d req=%b miss=%b dirty=%b ack=%b latency=%0d", i,
               vt[i].req, vt[i].miss, vt[i].dirty, vt[i].ack_f, lat);
    end

    // Slow memory: three wait cycles per word.
    ack_delay  = 3;
    upd_before = n_upd;
    start_miss(1'b1, $urandom, 6'($urandom),
               {$urandom, $urandom, $urandom, $urandom}, $urandom);
    wait_idle(lat);
    ack_delay = 0;
    chk("slow_latency", lat, 33);
    chk("slow_update_once", n_upd - upd_before, 1);
    chk("slow_xq_empty", xq.size(), 0);
    chk_counts();
    $display("slow miss: latency %0d", lat);

    // Reset after two fill words aborts the refill.
    upd_before = n_upd;
    start_miss(1'b0, $urandom, 6'($urandom), 128'h0, 32'hBEEF_0000);
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("abort_update", update, 1'b0);
    chk("abort_d", d, 128'h0);
    chk("abort_stall", stall, 1'b0);
    chk("abort_mem_req", mem_req, 1'b0);
    chk("abort_mem_we", mem_we, 1'b0);
    chk("abort_mem_addr", mem_addr, 8'h0);
    chk("abort_mem_wdata", mem_wdata, 32'h0);
    chk("abort_words_done", xq.size(), 2);
    xq.delete();
    lq.delete();
    exp_fills = 0;
    exp_wbs   = 0;
    chk_counts();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_update", n_upd - upd_before, 0);
    chk("abort_idle_stall", stall, 1'b0);
    $display("reset abort: outputs cleared");

    start_miss(1'b0, 32'h0000_00C8, 6'h3F, 128'h0, 32'h7700_0010);
    wait_idle(lat);
    chk("restart_latency", lat, 5);
    chk_counts();
    $display("restart miss: latency %0d", lat);

    // Enough dirty misses to saturate the 2-bit counters.
    for (int i = 0; i < 4; i++) begin
      start_miss(1'b1, $urandom, 6'($urandom),
                 {$urandom, $urandom, $urandom, $urandom}, $urandom);
      wait_idle(lat);
      chk($sformatf("sat%0d_latency", i), lat, 9);
      chk_counts();
      $display("sat miss %0d: fill_cnt %0d sat_fill_cnt %0d sat_wb_cnt %0d",
               i, fill_cnt, s_fill_cnt, s_wb_cnt);
    end

    chk("end_xq_empty", xq.size(), 0);
    chk("end_lq_empty", lq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
